// File: rtl/nand_gates_pkg.sv
// -----------------------------------------------------------------------------
// nand_gates_pkg
//
// Purpose:
//   Shared definitions for the nand_three bring-up exerciser: sweep FSM state
//   encoding, vector-space constants and the golden three-input NAND function
//   that each sampled Y is checked against.
//
// Contents:
//   NUM_VECTORS    number of input combinations in one sweep (2^VEC_W)
//   VEC_W          width of the {a,b,c} stimulus vector
//   state_t        exerciser FSM states
//   nand3_expected golden Y for a given {a,b,c} vector
// -----------------------------------------------------------------------------
package nand_gates_pkg;

    localparam int unsigned VEC_W       = 3;
    localparam int unsigned NUM_VECTORS = 1 << VEC_W;

    // Last vector of a sweep; reaching it in SAMPLE ends the sweep.
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_t;

    // Golden model of nand_three: Y = ~(A & B & C), vec = {A, B, C}.
    function automatic logic nand3_expected(input logic [VEC_W-1:0] vec);
        return ~(&vec);
    endfunction

endpackage

// File: rtl/nand_three_exerciser.sv
// -----------------------------------------------------------------------------
// nand_three_exerciser
//
// Purpose:
//   Self-checking stimulus stage for a single nand_three gate, used during
//   hardware bring-up where no simulator monitor exists. On a start request it
//   walks {a,b,c} through all eight combinations, holds each one for
//   SETTLE_CYCLES clocks, samples y for one clock and compares it with the
//   golden NAND value. At the end of the sweep it pulses done and leaves a
//   pass flag, a saturating mismatch count and the first failing vector on
//   its outputs until the next accepted start.
//
// Parameters:
//   SETTLE_CYCLES  clocks each vector is held before y is sampled (>= 1)
//   ERR_W          width of the saturating mismatch counter
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      one-cycle sweep request, honoured only when idle
//   a           out  1      drive to nand_three A (vector bit 2, MSB)
//   b           out  1      drive to nand_three B (vector bit 1)
//   c           out  1      drive to nand_three C (vector bit 0, LSB)
//   y           in   1      nand_three Y, combinational from a/b/c
//   busy        out  1      high while a sweep is in progress
//   done        out  1      one-cycle pulse at end of sweep
//   pass        out  1      last completed sweep had zero mismatches
//   err_count   out  ERR_W  mismatches in the last or current sweep, saturating
//   fail_valid  out  1      at least one mismatch in the current or last sweep
//   fail_vec    out  3      {a,b,c} of the first mismatching vector
// -----------------------------------------------------------------------------
module nand_three_exerciser
    import nand_gates_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);

    // The settle counter counts up to SETTLE_CYCLES inclusive on the last
    // settle cycle, so it needs room for that value.
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [CNT_W-1:0]   r_settle;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic               r_fail_valid;
    logic [VEC_W-1:0]   r_fail_vec;

    // Next-state values
    state_t             w_state_nxt;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic [CNT_W-1:0]   w_settle_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic [ERR_W-1:0]   w_err_nxt;
    logic               w_fail_valid_nxt;
    logic [VEC_W-1:0]   w_fail_vec_nxt;

    // Sample-time helpers
    logic               w_mismatch;
    logic               w_err_sat;

    assign w_mismatch = (y != nand3_expected(r_vec));
    assign w_err_sat  = &r_err;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_vec_nxt        = r_vec;
        w_settle_nxt     = r_settle;
        w_pass_nxt       = r_pass;
        w_err_nxt        = r_err;
        w_fail_valid_nxt = r_fail_valid;
        w_fail_vec_nxt   = r_fail_vec;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    // Results of the previous sweep are dropped only here, so
                    // they stay readable for as long as the exerciser is idle.
                    w_err_nxt        = '0;
                    w_fail_valid_nxt = 1'b0;
                    w_fail_vec_nxt   = '0;
                    w_pass_nxt       = 1'b0;
                    w_vec_nxt        = '0;
                    w_settle_nxt     = '0;
                    w_state_nxt      = StSettle;
                end
            end

            StSettle: begin
                w_settle_nxt = r_settle + CNT_W'(1);
                if (r_settle == SETTLE_LAST) begin
                    w_state_nxt = StSample;
                end
            end

            StSample: begin
                if (w_mismatch) begin
                    if (!w_err_sat) begin
                        w_err_nxt = r_err + ERR_ONE;
                    end
                    // Only the first failure of the sweep is recorded.
                    if (!r_fail_valid) begin
                        w_fail_vec_nxt   = r_vec;
                        w_fail_valid_nxt = 1'b1;
                    end
                end

                if (r_vec == VEC_LAST) begin
                    w_state_nxt = StDone;
                end else begin
                    w_vec_nxt    = r_vec + VEC_W'(1);
                    w_settle_nxt = '0;
                    w_state_nxt  = StSettle;
                end
            end

            StDone: begin
                // fail_valid already includes the vec 7 sample taken in the
                // preceding SAMPLE cycle.
                w_pass_nxt  = ~r_fail_valid;
                w_vec_nxt   = '0;
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // busy/done are registered copies of the state being entered, so they
        // line up with the state rather than lagging it by a cycle.
        w_busy_nxt = (w_state_nxt == StSettle) || (w_state_nxt == StSample);
        w_done_nxt = (w_state_nxt == StDone);
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_vec        <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_settle     <= w_settle_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err        <= w_err_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_vec   <= w_fail_vec_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign a          = r_vec[2];
    assign b          = r_vec[1];
    assign c          = r_vec[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_nand_three_exerciser.sv
// -----------------------------------------------------------------------------
// tb_nand_three_exerciser
//
// Bench for nand_three_exerciser. The main instance drives a behavioural
// nand_three whose behaviour is switched per sweep (good gate, stuck-at-1,
// stuck-at-0, inverted gate). A second instance with ERR_W=3 always sees an
// inverted gate, so its counter must saturate.
// -----------------------------------------------------------------------------
module tb_nand_three_exerciser;

    localparam int unsigned SETTLE = 2;
    localparam int SWEEP_LEN = 1 + 8 * (SETTLE + 1);   // done cycle, 25

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a, b, c, y;
    logic       busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] fail_vec;

    logic       s_a, s_b, s_c, s_y;
    logic       s_busy, s_done, s_pass, s_fail_valid;
    logic [2:0] s_err_count;
    logic [2:0] s_fail_vec;

    int mode;   // 0 good gate, 1 stuck-at-1, 2 stuck-at-0, 3 AND gate

    int checks;
    int errors;

    typedef struct {
        logic [2:0] vec;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    nand_three_exerciser #(
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .c          (c),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    nand_three_exerciser #(
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (3)
    ) u_dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (s_a),
        .b          (s_b),
        .c          (s_c),
        .y          (s_y),
        .busy       (s_busy),
        .done       (s_done),
        .pass       (s_pass),
        .err_count  (s_err_count),
        .fail_valid (s_fail_valid),
        .fail_vec   (s_fail_vec)
    );

    function automatic logic model_y(input int m, input logic [2:0] v);
        case (m)
            0:       return ~(v[2] & v[1] & v[0]);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return v[2] & v[1] & v[0];
        endcase
    endfunction

    always_comb begin
        y = model_y(mode, {a, b, c});
    end

    assign s_y = s_a & s_b & s_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full sweep. Called on a negedge; start is seen at the next posedge
    // (cycle 0). Returns on the negedge of cycle 26, the idle cycle after done.
    // start_mask[n] drives start during cycle n to probe ignored requests.
    task automatic sweep(input int m, input logic [31:0] start_mask);
        int         exp_err;
        logic       exp_fv;
        logic [2:0] exp_fvec;
        exp_t       e;
        logic [2:0] v;

        mode     = m;
        exp_err  = 0;
        exp_fv   = 1'b0;
        exp_fvec = 3'b000;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            if (model_y(m, v) != ~(v[2] & v[1] & v[0])) begin
                exp_err++;
                if (!exp_fv) begin
                    exp_fv   = 1'b1;
                    exp_fvec = v;
                end
            end
        end

        for (int n = 1; n <= SWEEP_LEN + 1; n++) begin
            if (n < SWEEP_LEN) begin
                e.vec  = 3'((n - 1) / (SETTLE + 1));
                e.busy = 1'b1;
                e.done = 1'b0;
            end else if (n == SWEEP_LEN) begin
                e.vec  = 3'd7;
                e.busy = 1'b0;
                e.done = 1'b1;
            end else begin
                e.vec  = 3'd0;
                e.busy = 1'b0;
                e.done = 1'b0;
            end
            sb.push_back(e);
        end

        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int n = 1; n <= SWEEP_LEN + 1; n++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("m%0d_c%0d_abc", m, n), 32'({a, b, c}), 32'(e.vec));
            check($sformatf("m%0d_c%0d_busy", m, n), 32'(busy), 32'(e.busy));
            check($sformatf("m%0d_c%0d_done", m, n), 32'(done), 32'(e.done));
            start = start_mask[n];
        end

        check($sformatf("m%0d_err_count", m), 32'(err_count), 32'(exp_err));
        check($sformatf("m%0d_fail_valid", m), 32'(fail_valid), 32'(exp_fv));
        check($sformatf("m%0d_fail_vec", m), 32'(fail_vec), 32'(exp_fvec));
        check($sformatf("m%0d_pass", m), 32'(pass), 32'(exp_err == 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        start  = 1'b0;
        rst_n  = 1'b0;

        // Reset values, no clock edge yet.
        #1;
        check("rst_abc", 32'({a, b, c}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_fail_valid", 32'(fail_valid), 32'd0);
        check("rst_fail_vec", 32'(fail_vec), 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Good gate, then chained sweeps: each start lands in the cycle
        // right after the previous done.
        sweep(0, 32'h0);
        sweep(1, 32'h0);
        sweep(2, 32'h0);
        sweep(3, 32'h0);
        check("sat_err_count", 32'(s_err_count), 32'd7);
        check("sat_fail_vec", 32'(s_fail_vec), 32'd0);
        check("sat_fail_valid", 32'(s_fail_valid), 32'd1);
        check("sat_pass", 32'(s_pass), 32'd0);

        // start during cycles 5, 12 and the done cycle must all be ignored.
        sweep(0, (32'd1 << 5) | (32'd1 << 12) | (32'd1 << SWEEP_LEN));
        @(negedge clk);
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_done", 32'(done), 32'd0);
        check("hold_pass", 32'(pass), 32'd1);
        check("hold_err", 32'(err_count), 32'd0);

        // Asynchronous reset in the middle of a stuck-at-0 sweep at vec 4.
        mode  = 2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_abc", 32'({a, b, c}), 32'd4);
        check("pre_rst_err", 32'(err_count), 32'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_abc", 32'({a, b, c}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_fail_valid", 32'(fail_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_three_exerciser.md
Name: nand_three_exerciser

Overview:
- Self-checking stimulus stage that sits directly upstream of nand_three.
- Drives the A/B/C inputs of nand_three through all 8 input combinations and samples its Y output after a settle window.
- Compares each sample against the expected NAND value and reports pass/fail, an error count and the first failing vector.
- Used in hardware bring-up, where no simulator monitor is available.

Parameters:
SETTLE_CYCLES, 2, cycles a vector is held before Y is sampled; legal range >= 1
ERR_W, 4, width of the error counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a full sweep; honoured only in IDLE
a  out  1  drive to nand_three A (vector bit 2, MSB)
b  out  1  drive to nand_three B (vector bit 1)
c  out  1  drive to nand_three C (vector bit 0, LSB)
y  in  1  nand_three Y output
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse at end of sweep
pass  out  1  level; 1 when the last completed sweep had zero errors
err_count  out  ERR_W  mismatches in the last or current sweep, saturating
fail_valid  out  1  level; at least one mismatch in the current or last sweep
fail_vec  out  3  {a,b,c} of the first mismatching vector

Behaviour:
- One clock domain. Reset is asynchronous, active-low. Clock and reset ports are named clk and rst_n.
- Reset values (asynchronous, take effect immediately):
  - state=IDLE, a=b=c=0, vec=0, settle counter=0.
  - busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
- All outputs are registered. {a,b,c} always equals the internal 3-bit vec register.
- States:
  - IDLE: busy=0. When start=1:
    - clear err_count, fail_valid, fail_vec and pass;
    - set vec=0 and settle counter=0;
    - go to SETTLE.
  - SETTLE: busy=1. Increment the settle counter. After SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
  - SAMPLE: busy=1, one cycle. Expected value = ~(a&b&c).
    - If y != expected: err_count increments, saturating at 2^ERR_W-1.
    - If y != expected and fail_valid=0: fail_vec<=vec and fail_valid<=1.
    - If vec==7: go to DONE.
    - Otherwise: vec<=vec+1, clear the settle counter, go to SETTLE.
  - DONE: one cycle.
    - done=1, busy=0.
    - pass<=1 only if no mismatch occurred during the sweep, including a mismatch on the vec 7 sample.
    - vec<=0, so a=b=c=0.
    - Next state is IDLE.
- Timing (start sampled at cycle 0):
  - vec k is driven from cycle 1+k*(SETTLE_CYCLES+1).
  - vec k is sampled at cycle (k+1)*(SETTLE_CYCLES+1).
  - done pulses at cycle 1+8*(SETTLE_CYCLES+1); this is cycle 25 for the default.
- start in any state other than IDLE is ignored; it is neither queued nor allowed to restart the sweep.
- start in the DONE cycle is ignored. start in the cycle after DONE is accepted.
- pass, err_count, fail_valid and fail_vec hold their values after DONE until the next accepted start.
- Reset asserted mid-sweep returns everything to reset values. The next start runs a full sweep beginning at vec 0.
- y is treated as combinational from a/b/c. No y synchronizer; same clock domain.

Decomposition:
- Shared package nand_gates_pkg holds:
  - state encoding typedef (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VECTORS=8 and VEC_W=3;
  - the expected-value function nand3_expected(vec).
- No sub-module. The settle counter and error counter are small enough to live inline. Top-level test wrapper instantiates nand_three_exerciser driving nand_three.

Test Plan:
1. Connect real nand_three, SETTLE_CYCLES=2, pulse start -> {a,b,c} steps 000..111 (each held 3 cycles); done at cycle 25; pass=1; err_count=0; fail_valid=0.
2. y forced 1 (stuck-at-1) -> err_count=1, fail_vec=3'b111, fail_valid=1, pass=0.
3. y forced 0 (stuck-at-0), ERR_W=4 -> err_count=7, fail_vec=3'b000, pass=0.
4. y = AND of inputs (inverted gate), ERR_W=3 -> 8 mismatches, err_count saturates at 7, fail_vec=3'b000.
5. start re-pulsed at cycles 5 and 12 of a sweep -> ignored; done still at cycle 25 only, with a single done pulse.
6. rst_n low while vec=4 -> a=b=c=0, busy=0, err_count=0 immediately without a clock edge; after release, start gives a full clean sweep with done 25 cycles later and pass=1.
